// File: rtl/control_botones_pkg.sv
// rtl/control_botones_pkg.sv - shared channel FSM state type and timing defaults
package control_botones_pkg;

  typedef enum logic [1:0] {
    REPOSO        = 2'd0,
    BLOQUEO       = 2'd1,
    ESPERA_SUELTA = 2'd2
  } estado_t;

  localparam int DEF_CICLOS_MS   = 50000;
  localparam int DEF_DURACION_MS = 20;

endpackage

// File: rtl/canal_rebote.sv
// rtl/canal_rebote.sv - one button channel: synchronizer, lockout FSM and press pulse
module canal_rebote
  import control_botones_pkg::*;
#(
  parameter logic [31:0] LIMITE = 32'd1000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_boton,
  output logic o_pulso,
  output logic o_ocupado
);

  logic [1:0]  r_sync;
  estado_t     r_estado;
  estado_t     w_estado_sig;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_sig;
  logic        w_nivel;

  assign w_nivel = r_sync[1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_boton};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_estado <= REPOSO;
      r_cnt    <= 32'd0;
    end else begin
      r_estado <= w_estado_sig;
      r_cnt    <= w_cnt_sig;
    end
  end

  // The level is only looked at in REPOSO and ESPERA_SUELTA; bounce during the lockout is invisible.
  always_comb begin
    w_estado_sig = r_estado;
    w_cnt_sig    = r_cnt;
    o_pulso      = 1'b0;
    case (r_estado)
      REPOSO: begin
        if (w_nivel) begin
          o_pulso      = 1'b1;
          w_cnt_sig    = 32'd0;
          w_estado_sig = BLOQUEO;
        end
      end
      BLOQUEO: begin
        w_cnt_sig = r_cnt + 32'd1;
        if (r_cnt == LIMITE - 32'd1) begin
          w_estado_sig = ESPERA_SUELTA;
        end
      end
      ESPERA_SUELTA: begin
        if (!w_nivel) begin
          w_estado_sig = REPOSO;
        end
      end
      default: begin
        w_estado_sig = REPOSO;
      end
    endcase
  end

  assign o_ocupado = (r_estado != REPOSO);

endmodule

// File: rtl/control_botones.sv
// rtl/control_botones.sv - debounced push-button channels feeding a round-robin event arbiter
module control_botones
  import control_botones_pkg::*;
#(
  parameter int N_BOT       = 4,
  parameter int CICLOS_MS   = DEF_CICLOS_MS,
  parameter int DURACION_MS = DEF_DURACION_MS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BOT-1:0]         botones,
  input  logic                     ack,
  output logic                     evento_valido,
  output logic [$clog2(N_BOT)-1:0] evento_id,
  output logic [N_BOT-1:0]         ocupado,
  output logic [7:0]               perdidos
);

  localparam int          ID_W   = $clog2(N_BOT);
  localparam logic [31:0] LIMITE = 32'(CICLOS_MS * DURACION_MS);

  logic [N_BOT-1:0] w_pulso;
  logic [N_BOT-1:0] r_pend;
  logic [N_BOT-1:0] w_conceder;
  logic             r_valido;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  r_ptr;
  logic [7:0]       r_perdidos;
  logic             w_carga;
  logic             w_hay;
  logic [ID_W-1:0]  w_sel;
  int               w_idx;
  logic [3:0]       w_n_perdidos;
  logic [8:0]       w_suma;

  for (genvar g = 0; g < N_BOT; g++) begin : g_canal
    canal_rebote #(
      .LIMITE(LIMITE)
    ) u_canal (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_boton   (botones[g]),
      .o_pulso   (w_pulso[g]),
      .o_ocupado (ocupado[g])
    );
  end

  assign w_carga = !r_valido || ack;

  // Search starts one past the last grant, wrapping, so every channel gets a turn.
  always_comb begin
    w_hay = 1'b0;
    w_sel = '0;
    w_idx = 0;
    for (int k = 1; k <= N_BOT; k++) begin
      w_idx = (int'(r_ptr) + k) % N_BOT;
      if (!w_hay && r_pend[w_idx[ID_W-1:0]]) begin
        w_hay = 1'b1;
        w_sel = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_conceder = (w_carga && w_hay) ? (N_BOT'(1) << w_sel) : '0;

  // A press on a channel whose flag is being granted this cycle just re-arms it, so it is not lost.
  always_comb begin
    w_n_perdidos = 4'd0;
    for (int i = 0; i < N_BOT; i++) begin
      w_n_perdidos = w_n_perdidos + 4'(w_pulso[i] & r_pend[i] & ~w_conceder[i]);
    end
  end

  assign w_suma = {1'b0, r_perdidos} + {5'd0, w_n_perdidos};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend     <= '0;
      r_valido   <= 1'b0;
      r_id       <= '0;
      r_ptr      <= ID_W'(N_BOT - 1);
      r_perdidos <= 8'd0;
    end else begin
      r_pend     <= (r_pend & ~w_conceder) | w_pulso;
      r_perdidos <= w_suma[8] ? 8'hFF : w_suma[7:0];
      if (w_carga) begin
        if (w_hay) begin
          r_valido <= 1'b1;
          r_id     <= w_sel;
          r_ptr    <= w_sel;
        end else begin
          r_valido <= 1'b0;
        end
      end
    end
  end

  assign evento_valido = r_valido;
  assign evento_id     = r_id;
  assign perdidos      = r_perdidos;

endmodule

// File: tb/tb_control_botones.sv
// tb/tb_control_botones.sv - scoreboard bench for control_botones with a 4-cycle lockout
module tb_control_botones;

  logic       clk = 1'b0;
  logic       rst;
  logic       ack;
  logic [3:0] botones;
  logic       evento_valido;
  logic [1:0] evento_id;
  logic [3:0] ocupado;
  logic [7:0] perdidos;

  int n_vec = 0;
  int n_err = 0;
  int n_ev  = 0;
  int mon_e;
  int exp_q[$];

  always #5 clk = ~clk;

  control_botones #(
    .N_BOT       (4),
    .CICLOS_MS   (2),
    .DURACION_MS (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .botones       (botones),
    .ack           (ack),
    .evento_valido (evento_valido),
    .evento_id     (evento_id),
    .ocupado       (ocupado),
    .perdidos      (perdidos)
  );

  // Handshakes are observed mid-cycle, after the inputs for the coming edge are settled.
  always begin
    @(negedge clk);
    #2;
    if (!rst && evento_valido && ack) begin
      n_ev++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_extra: got id %0d, expected no event", evento_id);
      end else begin
        mon_e = exp_q.pop_front();
        if (evento_id !== 2'(mon_e)) begin
          n_err++;
          $display("FAIL scoreboard_id: got %0d, expected %0d", evento_id, mon_e);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; botones = 4'b0; ack = 1'b0;
    cyc(3);
    n_vec++; if (evento_valido !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0d, expected 0", evento_valido); end
    n_vec++; if (evento_id !== 2'd0) begin n_err++; $display("FAIL rst_id: got %0d, expected 0", evento_id); end
    n_vec++; if (ocupado !== 4'b0) begin n_err++; $display("FAIL rst_ocupado: got %b, expected 0000", ocupado); end
    n_vec++; if (perdidos !== 8'd0) begin n_err++; $display("FAIL rst_perdidos: got %0d, expected 0", perdidos); end
    rst = 1'b0;
    cyc(2);
  endtask

  task automatic test_simultaneous();
    ack = 1'b1;
    cyc(1);
    botones = 4'b1101;
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(3);
    for (int s = 0; s < 3; s++) begin
      cyc(1);
      n_vec++; if (evento_valido !== 1'b0) begin n_err++; $display("FAIL sim_latency%0d: got valid %0d, expected 0", s, evento_valido); end
    end
    cyc(1);
    n_vec++; if (evento_valido !== 1'b1 || evento_id !== 2'd0) begin n_err++; $display("FAIL sim_first: got valid %0d id %0d, expected 1 id 0", evento_valido, evento_id); end
    n_vec++; if (ocupado !== 4'b1101) begin n_err++; $display("FAIL sim_ocupado: got %b, expected 1101", ocupado); end
    cyc(1);
    n_vec++; if (evento_valido !== 1'b1 || evento_id !== 2'd2) begin n_err++; $display("FAIL sim_second: got valid %0d id %0d, expected 1 id 2", evento_valido, evento_id); end
    cyc(1);
    n_vec++; if (evento_valido !== 1'b1 || evento_id !== 2'd3) begin n_err++; $display("FAIL sim_third: got valid %0d id %0d, expected 1 id 3", evento_valido, evento_id); end
    cyc(1);
    n_vec++; if (evento_valido !== 1'b0) begin n_err++; $display("FAIL sim_empty: got valid %0d, expected 0", evento_valido); end
    botones = 4'b0;
    cyc(12);
    ack = 1'b0;
  endtask

  task automatic test_bounce();
    int ev0;
    ev0 = n_ev;
    ack = 1'b0;
    botones[1] = 1'b1;
    exp_q.push_back(1);
    cyc(1);
    n_vec++; if (evento_valido !== 1'b0) begin n_err++; $display("FAIL bounce_lat0: got valid %0d, expected 0", evento_valido); end
    botones[1] = 1'b0;
    cyc(1);
    n_vec++; if (evento_valido !== 1'b0) begin n_err++; $display("FAIL bounce_lat1: got valid %0d, expected 0", evento_valido); end
    botones[1] = 1'b1;
    cyc(1);
    n_vec++; if (evento_valido !== 1'b0) begin n_err++; $display("FAIL bounce_lat2: got valid %0d, expected 0", evento_valido); end
    botones[1] = 1'b0;
    cyc(1);
    n_vec++; if (evento_valido !== 1'b1 || evento_id !== 2'd1) begin n_err++; $display("FAIL bounce_event: got valid %0d id %0d, expected 1 id 1", evento_valido, evento_id); end
    botones[1] = 1'b1;
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    n_vec++; if (evento_valido !== 1'b0) begin n_err++; $display("FAIL bounce_accepted: got valid %0d, expected 0", evento_valido); end
    cyc(10);
    botones = 4'b0;
    cyc(12);
    n_vec++; if (n_ev - ev0 !== 1) begin n_err++; $display("FAIL bounce_count: got %0d events, expected 1", n_ev - ev0); end
    n_vec++; if (perdidos !== 8'd0) begin n_err++; $display("FAIL bounce_perdidos: got %0d, expected 0", perdidos); end
    n_vec++; if (ocupado !== 4'b0) begin n_err++; $display("FAIL bounce_idle: got %b, expected 0000", ocupado); end
  endtask

  task automatic test_hold_release();
    int ev0;
    ev0 = n_ev;
    ack = 1'b1;
    botones[2] = 1'b1;
    exp_q.push_back(2);
    cyc(50);
    n_vec++; if (ocupado !== 4'b0100) begin n_err++; $display("FAIL hold_ocupado: got %b, expected 0100", ocupado); end
    botones = 4'b0;
    cyc(12);
    botones[2] = 1'b1;
    exp_q.push_back(2);
    cyc(12);
    botones = 4'b0;
    cyc(12);
    n_vec++; if (n_ev - ev0 !== 2) begin n_err++; $display("FAIL hold_count: got %0d events, expected 2", n_ev - ev0); end
    ack = 1'b0;
  endtask

  task automatic test_overflow_ack();
    int ev0;
    ev0 = n_ev;
    ack = 1'b0;
    for (int p = 0; p < 3; p++) begin
      botones[0] = 1'b1;
      if (p < 2) exp_q.push_back(0);
      cyc(10);
      botones[0] = 1'b0;
      cyc(10);
    end
    n_vec++; if (evento_valido !== 1'b1 || evento_id !== 2'd0) begin n_err++; $display("FAIL ovf_present: got valid %0d id %0d, expected 1 id 0", evento_valido, evento_id); end
    n_vec++; if (perdidos !== 8'd1) begin n_err++; $display("FAIL ovf_perdidos: got %0d, expected 1", perdidos); end
    ack = 1'b1;
    cyc(6);
    ack = 1'b0;
    n_vec++; if (n_ev - ev0 !== 2) begin n_err++; $display("FAIL ovf_count: got %0d events, expected 2", n_ev - ev0); end
    n_vec++; if (evento_valido !== 1'b0) begin n_err++; $display("FAIL ovf_drained: got valid %0d, expected 0", evento_valido); end
  endtask

  task automatic test_reset_mid();
    ack = 1'b0;
    botones[1] = 1'b1;
    cyc(4);
    n_vec++; if (evento_valido !== 1'b1 || ocupado !== 4'b0010) begin n_err++; $display("FAIL mid_before: got valid %0d ocupado %b, expected 1 and 0010", evento_valido, ocupado); end
    rst = 1'b1;
    #1;
    n_vec++; if (evento_valido !== 1'b0 || evento_id !== 2'd0) begin n_err++; $display("FAIL mid_async_valid: got valid %0d id %0d, expected 0 id 0", evento_valido, evento_id); end
    n_vec++; if (ocupado !== 4'b0 || perdidos !== 8'd0) begin n_err++; $display("FAIL mid_async_state: got ocupado %b perdidos %0d, expected 0000 and 0", ocupado, perdidos); end
    botones = 4'b0;
    cyc(2);
    rst = 1'b0;
    cyc(12);
    n_vec++; if (evento_valido !== 1'b0 || ocupado !== 4'b0) begin n_err++; $display("FAIL mid_no_event: got valid %0d ocupado %b, expected 0 and 0000", evento_valido, ocupado); end
  endtask

  task automatic test_held_through_reset();
    botones[3] = 1'b1;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    exp_q.push_back(3);
    for (int s = 0; s < 3; s++) begin
      cyc(1);
      n_vec++; if (evento_valido !== 1'b0) begin n_err++; $display("FAIL held_latency%0d: got valid %0d, expected 0", s, evento_valido); end
    end
    cyc(1);
    n_vec++; if (evento_valido !== 1'b1 || evento_id !== 2'd3) begin n_err++; $display("FAIL held_event: got valid %0d id %0d, expected 1 id 3", evento_valido, evento_id); end
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    n_vec++; if (evento_valido !== 1'b0) begin n_err++; $display("FAIL held_accepted: got valid %0d, expected 0", evento_valido); end
    botones = 4'b0;
    cyc(12);
  endtask

  task automatic test_saturate();
    ack = 1'b0;
    for (int p = 0; p < 300; p++) begin
      botones[2] = 1'b1;
      if (p < 2) exp_q.push_back(2);
      cyc(8);
      botones[2] = 1'b0;
      cyc(8);
      if (p == 9) begin
        n_vec++; if (perdidos !== 8'd8) begin n_err++; $display("FAIL sat_partial: got %0d, expected 8", perdidos); end
      end
    end
    n_vec++; if (perdidos !== 8'd255) begin n_err++; $display("FAIL sat_perdidos: got %0d, expected 255", perdidos); end
    n_vec++; if (evento_valido !== 1'b1 || evento_id !== 2'd2) begin n_err++; $display("FAIL sat_present: got valid %0d id %0d, expected 1 id 2", evento_valido, evento_id); end
    ack = 1'b1;
    cyc(6);
    ack = 1'b0;
    n_vec++; if (evento_valido !== 1'b0) begin n_err++; $display("FAIL sat_drained: got valid %0d, expected 0", evento_valido); end
  endtask

  task automatic test_drained();
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_left: got %0d outstanding, expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_bounce();
    test_hold_release();
    test_overflow_ack();
    test_reset_mid();
    test_held_through_reset();
    test_saturate();
    test_drained();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/control_botones.md
CONTROL_BOTONES -- requirements
Module: control_botones

Interface
REQ-001 The block SHALL take parameter N_BOT, default 4, meaning the number of push-button channels (2..8).
REQ-002 The block SHALL take parameter CICLOS_MS, default 50000, meaning clk cycles per millisecond.
REQ-003 The block SHALL take parameter DURACION_MS, default 20, meaning the lockout duration in milliseconds.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port botones, input, N_BOT bits: raw asynchronous button levels, active-high.
REQ-007 The block SHALL have port ack, input, 1 bit: the consumer accepts the presented event.
REQ-008 The block SHALL have port evento_valido, output, 1 bit: an event is presented.
REQ-009 The block SHALL have port evento_id, output, clog2(N_BOT) bits: the index of the presented button.
REQ-010 The block SHALL have port ocupado, output, N_BOT bits: the channel is in lockout or waiting for release.
REQ-011 The block SHALL have port perdidos, output, 8 bits: a saturating count of presses lost to overflow.

Function
REQ-012 Each botones bit SHALL pass a two-flop synchronizer before any use.
REQ-013 Each channel SHALL run an FSM with states REPOSO, BLOQUEO and ESPERA_SUELTA.
REQ-014 In REPOSO, a synchronized level of 1 SHALL set the channel pending flag, clear its counter and move the FSM to BLOQUEO.
REQ-015 In BLOQUEO, the counter SHALL increment each cycle, and on reaching CICLOS_MS*DURACION_MS-1 the FSM SHALL move to ESPERA_SUELTA.
REQ-016 Input level SHALL be ignored throughout BLOQUEO.
REQ-017 In ESPERA_SUELTA, a synchronized level of 0 SHALL return the FSM to REPOSO, so a held button produces exactly one event.
REQ-018 The counter SHALL be 32 bits wide, unsigned, and its product limit SHALL be computed at elaboration.
REQ-019 ocupado[i] SHALL be 1 whenever channel i is in BLOQUEO or ESPERA_SUELTA.
REQ-020 A press detected while the channel pending flag is already 1 SHALL increment perdidos, saturating at 255; the pending flag stays 1.
REQ-021 The arbiter SHALL load the output register when evento_valido=0, or when evento_valido=1 and ack=1 in the same cycle.
REQ-022 When loading, the arbiter SHALL grant round-robin, starting at the channel after the last granted one.
REQ-023 A grant SHALL set evento_valido=1, load evento_id and clear the granted pending flag in that cycle.
REQ-024 If no flag is pending at load time, evento_valido SHALL go to 0.
REQ-025 A new press and a grant on the same channel in the same cycle SHALL leave the pending flag set; set wins.
REQ-026 evento_id SHALL be held stable while evento_valido=1 and ack=0.
REQ-027 ack while evento_valido=0 SHALL be ignored.
REQ-028 Throughput SHALL be one event per cycle when ack is held high.
REQ-029 With the block idle, a raw rise sampled at edge k SHALL produce evento_valido=1 after edge k+3; latency is 4 edges in total.
REQ-030 The last-granted pointer after reset SHALL be N_BOT-1, so that channel 0 has first priority.

Reset
REQ-031 While rst=1, asynchronously: synchronizers 0, every FSM REPOSO, counters 0, pending flags 0, evento_valido 0, evento_id 0, ocupado 0, perdidos 0, pointer N_BOT-1.
REQ-032 Reset asserted mid-lockout or mid-handshake SHALL drop the presented event and any pending events without counting them as lost.
REQ-033 After rst falls, a button already held SHALL be treated as a new press, producing an event 4 edges later.

Structure
REQ-034 Package control_botones_pkg SHALL hold the FSM state typedef (REPOSO, BLOQUEO, ESPERA_SUELTA) and the defaults CICLOS_MS and DURACION_MS.
REQ-035 Sub-module canal_rebote SHALL contain the synchronizer, FSM, counter and press-detect pulse for one channel, instantiated N_BOT times.
REQ-036 The arbiter, pending flags and perdidos SHALL live in control_botones.

Verification (CICLOS_MS=2, DURACION_MS=2, lockout 4 cycles, N_BOT=4)
REQ-037 A single press on bit 1 with bouncing on cycles 5..7 and ack at first valid SHALL produce exactly one event with id=1, valid rising 4 edges after the first rise, and perdidos=0.
REQ-038 Simultaneous presses on bits 0, 2 and 3 with ack held high SHALL produce ids 0, 2, 3 on consecutive cycles.
REQ-039 Bit 2 held for 50 cycles, released, then pressed again SHALL produce exactly two events.
REQ-040 Three presses on bit 0 while ack=0, each after release, SHALL present id=0, leave pending=1, and give perdidos=1; two events follow after ack.
REQ-041 rst pulsed during BLOQUEO with evento_valido=1 SHALL clear all outputs immediately, with no event until a new press.
REQ-042 300 overflow presses on one channel SHALL leave perdidos at 255.
